blit_loop_cnt: RTL and testbench
================================

# blit_loop_cnt

Parametrised nested loop counter for the blitter address sequencer, generalising the single 16-bit outer down-counter to `LEVELS` cascaded levels of `WIDTH` bits each. Each level has a reload register. Inner levels auto-reload and carry into the next level when they expire. The outermost level's zero flag is the blit-complete condition. The block sits between the GPU register write decode (loads) and the blitter state machine (step requests, done and wrap indications).

## Interface
- `WIDTH`, 16, bits per level counter and reload register (2..16).
- `LEVELS`, 2, number of nested levels (1..4); level 0 is innermost, level `LEVELS-1` is outermost.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `resetl`  in  1  reset, asynchronous, active-low.
- `din`  in  WIDTH  load data (GPU data bus field selected by the decoder).
- `ld`  in  LEVELS  bit i loads `din` into both reload register i and counter i.
- `step`  in  1  one innermost iteration completed.
- `count`  out  LEVELS*WIDTH  current counters; level i occupies bits [i*WIDTH +: WIDTH].
- `zero`  out  LEVELS  bit i high when counter i == 0 (combinational from registers).
- `wrap`  out  LEVELS  bit i is a registered one-cycle pulse: level i expired on the step just taken.
- `done`  out  1  equals `zero[LEVELS-1]`; blit complete or no work loaded.

## Operation
- **Count semantics:**
  - A counter value N means N iterations remain at that level.
  - An inner level holding 0 means 2^WIDTH; a decrement from 0 wraps to all-ones.
  - Outermost 0 means finished.
- **Load:** `ld[i]` writes `din` to reload[i] and count[i]; several `ld` bits may be set in one cycle.
- **Step** is accepted only when `done`=0 and `ld`=0. Otherwise it is ignored and no state changes.
- **Accepted step, per level** (level 0 always steps; level i>0 steps only if level i-1 expires):
  - If count[i] != 1: count[i] decrements by 1 (mod 2^WIDTH). The level does not expire.
  - If count[i] == 1 and i < LEVELS-1: the level expires.
    - If level i+1 will also reach 0 (its count is 1 and it steps), count[i] goes to 0 with no reload.
    - Otherwise count[i] reloads from reload[i]. Level i+1 steps.
  - If count[i] == 1 and i == LEVELS-1: count goes to 0, the level expires, and `done` rises.
- **Final step:** all levels go to 0.
- **Carry chain:** resolved in the same cycle; a ripple of up to `LEVELS` levels completes in one edge.
- **wrap:** `wrap[i]` is set for each level that expired on the accepted step, and is cleared on the next edge.
- **LEVELS=1:** degenerates to a single loadable down-counter with a zero flag.

## Timing
- **Reset** (asynchronous assert, synchronous-safe release):
  - count = 0 and reload = 0.
  - `zero` = all ones, `done` = 1, `wrap` = 0.
- **Step latency:** one cycle. A step sampled at edge k shows updated `count`/`zero`/`done` and the `wrap` pulse after edge k.
- **Back-to-back steps** every cycle are supported; no bubbles.
- **`done` reaction time:** `done` is valid in the same cycle as the counter update. The blitter must not issue a further step after seeing `done`; if it does, the step is ignored.
- **ld versus step:** `ld` in the same cycle as `step` takes priority. The loaded values appear after the edge, the step is dropped, and `wrap` is 0.
- **Reset mid-blit:** all state is cleared immediately. No `wrap` pulse is generated.

## Structure
- Shared package `blit_pkg`:
  - `BLIT_MAX_LEVELS` = 4.
  - `BLIT_CNT_W` default = 16.
  - Typedef `blit_cnt_t` (WIDTH-bit count).
- Sub-module `loop_cnt_level`, instantiated `LEVELS` times via generate.
  - Contains one reload register and one counter.
  - Inputs: `clk`, `resetl`, `din`, `ld`, `en`, `next_zero`.
  - Outputs: `count`, `zero`, `expire`.
- Top level holds:
  - The carry chain: level i+1's `en` is level i's `expire`, gated by the global accept.
  - The `wrap` register.
  - The `done` assignment.

## Test plan
- **Reset:** assert `resetl`=0 mid-count → count=0, done=1, zero=all ones, wrap=0 immediately (no clock needed).
- **Nested 3×2** (LEVELS=2, WIDTH=16): ld both with inner=3, outer=2; issue 6 steps.
  - Inner sequence: 2,1,3,2,1,0.
  - Outer sequence: 2,2,1,1,1,0.
  - `wrap[0]` pulses after steps 3 and 6; `wrap[1]` and `done` only after step 6.
- **Inner zero = 2^WIDTH** (WIDTH=4): inner=0, outer=1 → 16 steps to done; first step shows inner=15.
- **ld/step collision:** step and ld[0]=5 in the same cycle → count0=5, others unchanged, wrap=0.
- **Step while done:** after completion, 3 further steps → count stays 0, no wrap pulses.
- **Ripple** (LEVELS=4): all levels loaded with 1 except level 3 = 2; one step.
  - Levels 0–2 reload to 1; level 3 becomes 1.
  - `wrap`=0b0111 for one cycle.

Source files
------------

// File: rtl/blit_loop_cnt_pkg.sv
// Shared constants and types for the blitter nested loop counter.
package blit_pkg;
   localparam int BLIT_MAX_LEVELS = 4;
   localparam int BLIT_CNT_W      = 16;

   typedef logic [BLIT_CNT_W-1:0] blit_cnt_t;
endpackage

// File: rtl/blit_loop_cnt_if.sv
// Load/step/status bundle between the register decode, blitter FSM and the loop counter.
interface blit_loop_cnt_if #(
   parameter int WIDTH  = 16,
   parameter int LEVELS = 2
);
   logic [WIDTH-1:0]        din;
   logic [LEVELS-1:0]       ld;
   logic                    step;
   logic [LEVELS*WIDTH-1:0] count;
   logic [LEVELS-1:0]       zero;
   logic [LEVELS-1:0]       wrap;
   logic                    done;

   modport master (output din, ld, step, input count, zero, wrap, done);
   modport slave  (input din, ld, step, output count, zero, wrap, done);
endinterface

// File: rtl/blit_loop_cnt_level.sv
// One loop level: reload register plus down-counter with expire/reload handling.
module loop_cnt_level
   import blit_pkg::*;
#(
   parameter int WIDTH = BLIT_CNT_W
) (
   input  logic             clk,
   input  logic             resetl,
   input  logic [WIDTH-1:0] din,
   input  logic             ld,
   input  logic             en,
   input  logic             next_zero,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             expire
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;

   // Expiring into a finishing outer level parks at 0 so the whole nest reads done.
   always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      if (ld) begin
         count_d  = din;
         reload_d = din;
      end else if (en) begin
         if (count_q == ONE) count_d = next_zero ? '0 : reload_q;
         else                count_d = count_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         count_q  <= '0;
         reload_q <= '0;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
      end
   end

   assign count  = count_q;
   assign zero   = (count_q == '0);
   assign expire = en && !ld && (count_q == ONE);
endmodule

// File: rtl/blit_loop_cnt.sv
// Nested loop counter: LEVELS cascaded down-counters with single-cycle carry ripple.
module blit_loop_cnt
   import blit_pkg::*;
#(
   parameter int WIDTH  = BLIT_CNT_W,
   parameter int LEVELS = 2
) (
   input  logic          clk,
   input  logic          resetl,
   blit_loop_cnt_if.slave bus
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [LEVELS-1:0][WIDTH-1:0] cnt;
   logic [LEVELS-1:0]            zero, expire, is_one, en, next_zero;
   logic [LEVELS-1:0]            wrap_q, wrap_d;
   logic                         accept;

   if (LEVELS < 1 || LEVELS > BLIT_MAX_LEVELS || WIDTH < 2 || WIDTH > BLIT_CNT_W) begin : g_bad_cfg
      $error("blit_loop_cnt: unsupported WIDTH/LEVELS");
   end

   assign accept = bus.step && !bus.done && (bus.ld == '0);

   always_comb begin
      for (int i = 0; i < LEVELS; i++) is_one[i] = (cnt[i] == ONE);
   end

   // Carry enables ripple up; "will reach zero" resolves down from the outermost level.
   always_comb begin
      en        = '0;
      next_zero = '0;
      en[0]     = accept;
      for (int i = 1; i < LEVELS; i++) en[i] = en[i-1] && is_one[i-1];
      next_zero[LEVELS-1] = 1'b1;
      for (int i = LEVELS - 2; i >= 0; i--) next_zero[i] = is_one[i+1] && next_zero[i+1];
   end

   for (genvar g = 0; g < LEVELS; g++) begin : g_lvl
      loop_cnt_level #(.WIDTH(WIDTH)) u_lvl (
         .clk       (clk),
         .resetl    (resetl),
         .din       (bus.din),
         .ld        (bus.ld[g]),
         .en        (en[g]),
         .next_zero (next_zero[g]),
         .count     (cnt[g]),
         .zero      (zero[g]),
         .expire    (expire[g])
      );
   end

   always_comb begin
      wrap_d = accept ? expire : '0;
   end

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) wrap_q <= '0;
      else         wrap_q <= wrap_d;
   end

   assign bus.count = cnt;
   assign bus.zero  = zero;
   assign bus.wrap  = wrap_q;
   assign bus.done  = zero[LEVELS-1];
endmodule

// File: tb/tb_blit_loop_cnt.sv
// Directed checks of the nested loop counter in three configurations.
module tb_blit_loop_cnt;
   logic clk = 1'b0;
   logic resetl = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   blit_loop_cnt_if #(.WIDTH(16), .LEVELS(2)) i2 ();
   blit_loop_cnt_if #(.WIDTH(4),  .LEVELS(2)) i4 ();
   blit_loop_cnt_if #(.WIDTH(4),  .LEVELS(4)) ir ();

   blit_loop_cnt #(.WIDTH(16), .LEVELS(2)) u2 (.clk(clk), .resetl(resetl), .bus(i2));
   blit_loop_cnt #(.WIDTH(4),  .LEVELS(2)) u4 (.clk(clk), .resetl(resetl), .bus(i4));
   blit_loop_cnt #(.WIDTH(4),  .LEVELS(4)) ur (.clk(clk), .resetl(resetl), .bus(ir));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int in_e[6]  = '{2, 1, 3, 2, 1, 0};
   int out_e[6] = '{2, 2, 1, 1, 1, 0};
   int wr_e[6]  = '{0, 0, 1, 0, 0, 3};

   initial begin
      i2.din = '0; i2.ld = '0; i2.step = 1'b0;
      i4.din = '0; i4.ld = '0; i4.step = 1'b0;
      ir.din = '0; ir.ld = '0; ir.step = 1'b0;
      cyc(); cyc();
      resetl = 1'b1;
      #1;
      chk("rst_count", i2.count, 32'h0);
      chk("rst_zero",  i2.zero,  2'b11);
      chk("rst_done",  i2.done,  1'b1);
      chk("rst_wrap",  i2.wrap,  2'b00);

      // nested 3 x 2
      i2.ld = 2'b01; i2.din = 16'd3; cyc();
      i2.ld = 2'b10; i2.din = 16'd2; cyc();
      i2.ld = 2'b00;
      chk("ld_count", i2.count, {16'd2, 16'd3});
      chk("ld_done",  i2.done,  1'b0);
      i2.step = 1'b1;
      for (int s = 0; s < 6; s++) begin
         cyc();
         chk($sformatf("nest_in%0d", s + 1),  i2.count[15:0],  64'(in_e[s]));
         chk($sformatf("nest_out%0d", s + 1), i2.count[31:16], 64'(out_e[s]));
         chk($sformatf("nest_wrap%0d", s + 1), i2.wrap, 64'(wr_e[s]));
         chk($sformatf("nest_done%0d", s + 1), i2.done, (s == 5) ? 64'd1 : 64'd0);
      end

      // steps after completion are ignored
      for (int s = 0; s < 3; s++) begin
         cyc();
         chk($sformatf("idle_cnt%0d", s), i2.count, 32'h0);
         chk($sformatf("idle_wrap%0d", s), i2.wrap, 2'b00);
      end
      i2.step = 1'b0;

      // ld/step collision
      i2.ld = 2'b01; i2.din = 16'd3; cyc();
      i2.ld = 2'b10; i2.din = 16'd2; cyc();
      i2.ld = 2'b01; i2.din = 16'd5; i2.step = 1'b1; cyc();
      i2.ld = 2'b00; i2.step = 1'b0;
      chk("coll_count", i2.count, {16'd2, 16'd5});
      chk("coll_wrap",  i2.wrap,  2'b00);
      i2.step = 1'b1; cyc(); i2.step = 1'b0;
      chk("coll_step", i2.count, {16'd2, 16'd4});

      // asynchronous reset mid-blit, no clock edge
      @(negedge clk);
      resetl = 1'b0;
      #1;
      chk("arst_count", i2.count, 32'h0);
      chk("arst_zero",  i2.zero,  2'b11);
      chk("arst_done",  i2.done,  1'b1);
      chk("arst_wrap",  i2.wrap,  2'b00);
      cyc();
      resetl = 1'b1;

      // inner 0 means 2^WIDTH iterations
      i4.ld = 2'b01; i4.din = 4'd0; cyc();
      i4.ld = 2'b10; i4.din = 4'd1; cyc();
      i4.ld = 2'b00; i4.step = 1'b1;
      cyc();
      chk("w4_first", i4.count, {4'd1, 4'd15});
      for (int s = 2; s <= 15; s++) cyc();
      chk("w4_s15_cnt",  i4.count, {4'd1, 4'd1});
      chk("w4_s15_done", i4.done,  1'b0);
      cyc();
      i4.step = 1'b0;
      chk("w4_s16_cnt",  i4.count, 8'h00);
      chk("w4_s16_done", i4.done,  1'b1);
      chk("w4_s16_wrap", i4.wrap,  2'b11);
      cyc();
      chk("w4_wrap_clr", i4.wrap, 2'b00);

      // four-level ripple
      ir.ld = 4'b0111; ir.din = 4'd1; cyc();
      ir.ld = 4'b1000; ir.din = 4'd2; cyc();
      ir.ld = 4'b0000;
      chk("rip_zero", ir.zero, 4'b0000);
      ir.step = 1'b1; cyc(); ir.step = 1'b0;
      chk("rip_count", ir.count, 16'h1111);
      chk("rip_wrap",  ir.wrap,  4'b0111);
      chk("rip_done",  ir.done,  1'b0);
      cyc();
      chk("rip_wrap_clr", ir.wrap, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
